// File: rtl/gf_sec32_pkg.sv
// Shared widths, check-bit masks and the codeword payload for the SEC32 encoder.
package gf_sec32_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CHK_W  = 8;
  localparam int unsigned CW_W   = 40;
  localparam int unsigned NB_W   = 3;
  localparam int unsigned POS_W  = 6;

  // Check bit k is the even parity of the data bits selected by CHK_MASK[k].
  localparam logic [DATA_W-1:0] CHK_MASK [CHK_W] = '{
    32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
    32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
  };

  // One buffered codeword with its framing information.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CHK_W-1:0]  chk;
    logic              last;
    logic [NB_W-1:0]   nbytes;
  } cw_entry_t;

  // Position of the next byte inside the word being packed.
  typedef enum logic [1:0] {
    IDX0 = 2'd0,
    IDX1 = 2'd1,
    IDX2 = 2'd2,
    IDX3 = 2'd3
  } byte_idx_e;

endpackage

// File: rtl/gf_sec32_parity.sv
// Purely combinational 32-bit to 8-bit check-bit generator.
module gf_sec32_parity
  import gf_sec32_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CHK_W-1:0]  chk_c
);

  // Each check bit is the XOR-reduction of its masked data bits.
  always_comb begin
    chk_c = '0;
    for (int unsigned k = 0; k < CHK_W; k++) begin
      chk_c[k] = ^(data & CHK_MASK[k]);
    end
  end

endmodule

// File: rtl/gf_sec32_encoder.sv
// Byte packer, check-bit generation, error injection and 2-entry output FIFO.
module gf_sec32_encoder
  import gf_sec32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  input  logic              inj_valid,
  input  logic [POS_W-1:0]  inj_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_chk,
  output logic              out_en,
  output logic              out_last,
  output logic [NB_W-1:0]   out_nbytes
);

  byte_idx_e        idx_q, idx_d;
  logic [23:0]      acc_q, acc_d;
  logic             armed_q, armed_d;
  logic [POS_W-1:0] pos_q, pos_d;
  cw_entry_t        e0_q, e0_d, e1_q, e1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic             vld_q, vld_d;

  logic             xfer_c, push_c, pop_c;
  logic [DATA_W-1:0] word_c;
  logic [CHK_W-1:0]  chk_c;
  logic [NB_W-1:0]   nbytes_c;
  logic              eff_armed_c;
  logic [POS_W-1:0]  eff_pos_c;
  logic [CW_W-1:0]   flip_c;
  logic [CW_W-1:0]   cw_c;
  cw_entry_t         new_c;

  gf_sec32_parity u_parity (
    .data  (word_c),
    .chk_c (chk_c)
  );

  // Merge the incoming byte into the partial word at the current index.
  always_comb begin
    word_c   = {8'h00, acc_q};
    nbytes_c = 3'd1;
    case (idx_q)
      IDX0:    begin word_c[7:0]   = in_byte; nbytes_c = 3'd1; end
      IDX1:    begin word_c[15:8]  = in_byte; nbytes_c = 3'd2; end
      IDX2:    begin word_c[23:16] = in_byte; nbytes_c = 3'd3; end
      IDX3:    begin word_c[31:24] = in_byte; nbytes_c = 3'd4; end
      default: begin word_c        = '0;      nbytes_c = 3'd1; end
    endcase
  end

  // Handshakes, injection selection and the codeword written to the FIFO.
  always_comb begin
    xfer_c      = in_valid & rdy_q;
    push_c      = xfer_c & (in_last | (idx_q == IDX3));
    pop_c       = vld_q & out_ready;
    eff_armed_c = inj_valid ? (inj_pos < POS_W'(CW_W)) : armed_q;
    eff_pos_c   = inj_valid ? inj_pos : pos_q;
    flip_c      = eff_armed_c ? (CW_W'(1) << eff_pos_c) : '0;
    cw_c        = {chk_c, word_c} ^ flip_c;
    new_c       = '{data:   cw_c[DATA_W-1:0],
                    chk:    cw_c[CW_W-1:DATA_W],
                    last:   in_last,
                    nbytes: nbytes_c};
  end

  // Next-state logic for packer, injection register and FIFO.
  always_comb begin
    idx_d   = idx_q;
    acc_d   = acc_q;
    armed_d = armed_q;
    pos_d   = pos_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    vld_d   = vld_q;

    if (inj_valid) begin
      armed_d = inj_pos < POS_W'(CW_W);
      pos_d   = inj_pos;
    end

    if (xfer_c) begin
      if (push_c) begin
        idx_d   = IDX0;
        acc_d   = '0;
        armed_d = 1'b0;
      end else begin
        acc_d = word_c[23:0];
        case (idx_q)
          IDX0:    idx_d = IDX1;
          IDX1:    idx_d = IDX2;
          IDX2:    idx_d = IDX3;
          default: idx_d = IDX0;
        endcase
      end
    end

    if (pop_c) begin
      e0_d = e1_q;
    end
    if (push_c) begin
      if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop_c)) begin
        e0_d = new_c;
      end else begin
        e1_d = new_c;
      end
    end

    cnt_d = cnt_q + 2'(push_c) - 2'(pop_c);
    rdy_d = cnt_d < 2'd2;
    vld_d = cnt_d != 2'd0;
  end

  // State registers; reset discards everything and holds in_ready low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= IDX0;
      acc_q   <= '0;
      armed_q <= 1'b0;
      pos_q   <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      armed_q <= armed_d;
      pos_q   <= pos_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready   = rdy_q;
  assign out_valid  = vld_q;
  assign out_en     = vld_q;
  assign out_data   = e0_q.data;
  assign out_chk    = e0_q.chk;
  assign out_last   = e0_q.last;
  assign out_nbytes = e0_q.nbytes;

endmodule

// File: tb/tb_gf_sec32_encoder.sv
// Self-checking bench for gf_sec32_encoder: vector table plus scoreboard.
module tb_gf_sec32_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        inj_valid;
  logic [5:0]  inj_pos;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_chk;
  logic        out_en;
  logic        out_last;
  logic [2:0]  out_nbytes;

  gf_sec32_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .in_last    (in_last),
    .inj_valid  (inj_valid),
    .inj_pos    (inj_pos),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_chk    (out_chk),
    .out_en     (out_en),
    .out_last   (out_last),
    .out_nbytes (out_nbytes)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  chk;
    logic        last;
    logic [2:0]  nbytes;
  } exp_t;

  typedef struct {
    logic [31:0] bytes;
    int          nb;
    logic        last;
    logic        inj;
    int          inj_at;
    logic [5:0]  pos;
    logic [31:0] exp_data;
    logic [7:0]  exp_chk;
  } vec_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference check bits from the mask table, bit by bit.
  function automatic logic [7:0] ref_chk(input logic [31:0] d);
    logic [31:0] m [8];
    logic [7:0]  c;
    m = '{32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
          32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0};
    c = '0;
    for (int k = 0; k < 8; k++)
      for (int b = 0; b < 32; b++)
        if (m[k][b]) c[k] = c[k] ^ d[b];
    return c;
  endfunction

  function automatic exp_t mk(input logic [31:0] d, input logic [7:0] c,
                              input logic l, input int nb);
    exp_t e;
    e.data = d; e.chk = c; e.last = l; e.nbytes = 3'(nb);
    return e;
  endfunction

  // Scoreboard: compare the head of the queue at every accepted output word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_word", 64'(out_data), 64'hDEAD);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_data",   64'(out_data),   64'(e.data));
        check("out_chk",    64'(out_chk),    64'(e.chk));
        check("out_last",   64'(out_last),   64'(e.last));
        check("out_nbytes", 64'(out_nbytes), 64'(e.nbytes));
        check("out_en",     64'(out_en),     64'(out_valid));
      end
    end
  end

  // Offer one byte until accepted (bounded); reports cycles taken.
  task automatic send_byte(input logic [7:0] b, input logic l, input logic iv,
                           input logic [5:0] p, output int n);
    logic got;
    in_valid = 1'b1; in_byte = b; in_last = l; inj_valid = iv; inj_pos = p;
    n = 0;
    do begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 200);
    if (!got) check("send_timeout", 64'(got), 64'd1);
    in_valid = 1'b0; in_last = 1'b0; inj_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];
    int   n, tot, acc;
    logic got;
    logic [31:0] w [3];
    logic [31:0] held;

    rst = 1'b1; in_valid = 1'b0; in_byte = '0; in_last = 1'b0;
    inj_valid = 1'b0; inj_pos = '0; out_ready = 1'b0;

    vt[0] = '{32'h00000001, 4, 1'b0, 1'b0, 0, 6'd0,  32'h00000001, 8'h51};
    vt[1] = '{32'hFFFFFFFF, 4, 1'b0, 1'b0, 0, 6'd0,  32'hFFFFFFFF, 8'h00};
    vt[2] = '{32'h00000001, 1, 1'b1, 1'b0, 0, 6'd0,  32'h00000001, 8'h51};
    vt[3] = '{32'h00010000, 4, 1'b0, 1'b0, 0, 6'd0,  32'h00010000, 8'h15};
    vt[4] = '{32'h00000001, 4, 1'b0, 1'b1, 0, 6'd0,  32'h00000000, 8'h51};
    vt[5] = '{32'h00000001, 4, 1'b0, 1'b0, 0, 6'd0,  32'h00000001, 8'h51};
    vt[6] = '{32'h00000001, 4, 1'b0, 1'b1, 3, 6'd35, 32'h00000001, 8'h59};
    vt[7] = '{32'h00000001, 4, 1'b0, 1'b1, 0, 6'd45, 32'h00000001, 8'h51};
    vt[8] = '{32'h00CCBBAA, 3, 1'b1, 1'b0, 0, 6'd0,  32'h00CCBBAA, ref_chk(32'h00CCBBAA)};
    vt[9] = '{32'h00003412, 2, 1'b1, 1'b1, 0, 6'd31, 32'h80003412, ref_chk(32'h00003412)};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", 64'({out_valid, out_data, out_chk, out_en, out_last, out_nbytes}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);
    out_ready = 1'b1;

    // Vector table.
    foreach (vt[i]) begin
      q.push_back(mk(vt[i].exp_data, vt[i].exp_chk, vt[i].last, vt[i].nb));
      for (int j = 0; j < vt[i].nb; j++) begin
        send_byte(vt[i].bytes[8*j +: 8], vt[i].last && (j == vt[i].nb - 1),
                  vt[i].inj && (j == vt[i].inj_at), vt[i].pos, n);
      end
    end
    drain();

    // Single-byte last words at one per cycle.
    tot = 0;
    for (int i = 0; i < 6; i++) begin
      q.push_back(mk(32'(8'h80 + i), ref_chk(32'(8'h80 + i)), 1'b1, 1));
      send_byte(8'(8'h80 + i), 1'b1, 1'b0, 6'd0, n);
      tot += n;
    end
    check("single_byte_rate", 64'(tot), 64'd6);
    drain();

    // Backpressure: only two words fit while out_ready is low.
    for (int k = 0; k < 3; k++) begin
      w[k] = {8'(8'h13 + 4*k), 8'(8'h12 + 4*k), 8'(8'h11 + 4*k), 8'(8'h10 + 4*k)};
      q.push_back(mk(w[k], ref_chk(w[k]), 1'b0, 4));
    end
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      in_byte = 8'(8'h10 + acc);
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) acc++;
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(acc), 64'd8);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_head_valid", 64'(out_valid), 64'd1);
    held = out_data;
    check("bp_head_data", 64'(out_data), 64'(w[0]));
    repeat (3) @(posedge clk);
    #1;
    check("bp_head_stable", 64'(out_data), 64'(held));
    out_ready = 1'b1;
    for (int k = acc; k < 12; k++) send_byte(8'(8'h10 + k), 1'b0, 1'b0, 6'd0, n);
    drain();
    check("bp_in_ready_back", 64'(in_ready), 64'd1);

    // Asynchronous reset mid-word discards the FIFO, partial word and armed flip.
    out_ready = 1'b0;
    send_byte(8'h01, 1'b0, 1'b0, 6'd0, n);
    send_byte(8'h02, 1'b0, 1'b0, 6'd0, n);
    send_byte(8'h03, 1'b0, 1'b0, 6'd0, n);
    send_byte(8'h04, 1'b0, 1'b0, 6'd0, n);
    send_byte(8'hAA, 1'b0, 1'b1, 6'd0, n);
    send_byte(8'hBB, 1'b0, 1'b0, 6'd0, n);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", 64'({out_valid, out_data, out_chk, out_en, out_last, out_nbytes}), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready_still_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("post_rst_ready_high", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    q.push_back(mk(32'h00000001, 8'h51, 1'b0, 4));
    send_byte(8'h01, 1'b0, 1'b0, 6'd0, n);
    send_byte(8'h00, 1'b0, 1'b0, 6'd0, n);
    send_byte(8'h00, 1'b0, 1'b0, 6'd0, n);
    send_byte(8'h00, 1'b0, 1'b0, 6'd0, n);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
